// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared state encoding and default width for serial_adder_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    localparam int SERIAL_ADDER_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/full_adder_1b.sv
// ============================================================================
// Module      : full_adder_1b
// Description : 1-bit full adder from two half adders and an OR of the carries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder_1b (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_s0;
    logic w_c0;
    logic w_c1;

    half_adder u_ha0 (
        .i_a     (i_a),
        .i_b     (i_b),
        .o_sum   (w_s0),
        .o_carry (w_c0)
    );

    half_adder u_ha1 (
        .i_a     (w_s0),
        .i_b     (i_cin),
        .o_sum   (o_sum),
        .o_carry (w_c1)
    );

    assign o_cout = w_c0 | w_c1;

endmodule : full_adder_1b

`default_nettype wire

// File: rtl/half_adder.sv
// ============================================================================
// Module      : half_adder
// Description : 1-bit half adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;

endmodule : half_adder

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial WIDTH-bit adder sequencing one shared full adder,
//               LSB first. Define SERIAL_ADDER_OVF_EN to add the overflow port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum_sh;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry_out;
    logic               w_fa_sum;
    logic               w_fa_cout;
    logic               w_last;
    logic [WIDTH-1:0]   w_sum_nxt;

    full_adder_1b u_fa (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    assign w_last    = (r_bit_cnt == c_LAST);
    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at LSB.
    assign w_sum_nxt = {w_fa_sum, r_sum_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_carry     <= 1'b0;
            r_bit_cnt   <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sh    <= a;
                        r_b_sh    <= b;
                        r_carry   <= 1'b0;
                        r_bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_a_sh    <= r_a_sh >> 1;
                    r_b_sh    <= r_b_sh >> 1;
                    r_sum_sh  <= w_sum_nxt;
                    r_carry   <= w_fa_cout;
                    r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                    if (w_last) begin
                        r_sum       <= w_sum_nxt;
                        r_carry_out <= w_fa_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_carry_out;

`ifdef SERIAL_ADDER_OVF_EN
    logic r_overflow;

    // On the last step r_carry is the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (r_state == ST_SHIFT && w_last) begin
            r_overflow <= r_carry ^ w_fa_cout;
        end
    end

    assign overflow = r_overflow;
`endif

endmodule : serial_adder_ctrl

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Scoreboard bench for serial_adder_ctrl at WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_ctrl;

    localparam int c_W = 8;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        logic       chk_gap;
    } res_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } snap_t;

    logic           clk;
    logic           rst;
    logic           start;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           busy;
    logic           done;
    logic [c_W-1:0] sum;
    logic           carry_out;
    logic           ovf_obs;

    res_t  q_res[$];
    snap_t q_snap[$];
    logic  end_req;

    int n_checks;
    int n_errors;

    serial_adder_ctrl #(.WIDTH(c_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .overflow  (ovf_obs)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf_obs = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_res(input logic [7:0] s, input logic c, input logic o,
                            input logic g);
        res_t r;
        r.sum = s; r.cout = c; r.ovf = o; r.chk_gap = g;
        q_res.push_back(r);
    endtask

    task automatic push_snap(input logic bs, input logic dn, input logic [7:0] s,
                             input logic c, input logic o);
        snap_t sn;
        sn.busy = bs; sn.done = dn; sn.sum = s; sn.cout = c; sn.ovf = o;
        q_snap.push_back(sn);
    endtask

    // Single request; operands are scrambled after the accepting edge.
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib,
                         input logic [7:0] es, input logic ec, input logic eo);
        start = 1'b1; a = ia; b = ib;
        push_res(es, ec, eo, 1'b0);
        @(posedge clk); #1;
        start = 1'b0; a = 8'($urandom); b = 8'($urandom);
        repeat (11) @(posedge clk);
        #1;
    endtask

    // Stimulus
    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; end_req = 1'b0;
        @(posedge clk); #1;
        push_snap(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        do_op(8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        do_op(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);

        // Second start during the 3rd SHIFT cycle must be ignored
        start = 1'b1; a = 8'h12; b = 8'h34;
        push_res(8'h46, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; a = 8'h55; b = 8'h55;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        // Reset at the 4th SHIFT cycle abandons the operation
        start = 1'b1; a = 8'hC3; b = 8'h5A;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        push_snap(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        do_op(8'hA0, 8'h60, 8'h00, 1'b1, 1'b0);

        // start held high: back-to-back, one result per WIDTH+2 cycles
        start = 1'b1; a = 8'h80; b = 8'h80;
        push_res(8'h00, 1'b1, 1'b1, 1'b0);
        push_res(8'h00, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        end_req = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        int    cyc;
        int    last_done;
        int    busy_len;
        int    wait_cnt;
        logic  prev_done;
        res_t  r;
        snap_t sn;
        cyc = 0; last_done = 0; busy_len = 0; wait_cnt = 0; prev_done = 1'b0;
        n_checks = 0; n_errors = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_done) begin
                n_checks++;
                if (done !== 1'b0) begin
                    n_errors++;
                    $display("FAIL done_width: done=%b required 0 one cycle after pulse", done);
                end
            end
            if (q_snap.size() > 0) begin
                sn = q_snap.pop_front();
                n_checks++;
                if (busy !== sn.busy) begin
                    n_errors++; $display("FAIL snap_busy: got %b required %b", busy, sn.busy);
                end
                n_checks++;
                if (done !== sn.done) begin
                    n_errors++; $display("FAIL snap_done: got %b required %b", done, sn.done);
                end
                n_checks++;
                if (sum !== sn.sum) begin
                    n_errors++; $display("FAIL snap_sum: got %h required %h", sum, sn.sum);
                end
                n_checks++;
                if (carry_out !== sn.cout) begin
                    n_errors++; $display("FAIL snap_cout: got %b required %b", carry_out, sn.cout);
                end
`ifdef SERIAL_ADDER_OVF_EN
                n_checks++;
                if (ovf_obs !== sn.ovf) begin
                    n_errors++; $display("FAIL snap_ovf: got %b required %b", ovf_obs, sn.ovf);
                end
`endif
            end
            if (done === 1'b1) begin
                if (q_res.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_done: got done=1 required no pulse (sum=%h)", sum);
                end else begin
                    r = q_res.pop_front();
                    n_checks++;
                    if (sum !== r.sum) begin
                        n_errors++; $display("FAIL sum: got %h required %h", sum, r.sum);
                    end
                    n_checks++;
                    if (carry_out !== r.cout) begin
                        n_errors++; $display("FAIL carry_out: got %b required %b", carry_out, r.cout);
                    end
`ifdef SERIAL_ADDER_OVF_EN
                    n_checks++;
                    if (ovf_obs !== r.ovf) begin
                        n_errors++; $display("FAIL overflow: got %b required %b", ovf_obs, r.ovf);
                    end
`endif
                    n_checks++;
                    if (busy_len != c_W || busy !== 1'b0) begin
                        n_errors++;
                        $display("FAIL busy_len: got %0d busy=%b required %0d busy=0",
                                 busy_len, busy, c_W);
                    end
                    if (r.chk_gap) begin
                        n_checks++;
                        if (cyc - last_done != c_W + 2) begin
                            n_errors++;
                            $display("FAIL throughput: got %0d cycles required %0d",
                                     cyc - last_done, c_W + 2);
                        end
                    end
                end
                last_done = cyc;
                wait_cnt  = 0;
            end else if (q_res.size() > 0) begin
                wait_cnt++;
                if (wait_cnt > 40) begin
                    n_checks++; n_errors++;
                    r = q_res.pop_front();
                    $display("FAIL timeout: got no done required sum %h", r.sum);
                    wait_cnt = 0;
                end
            end
            busy_len  = (busy === 1'b1) ? busy_len + 1 : 0;
            prev_done = (done === 1'b1);
            if (end_req) begin
                n_checks++;
                if (q_res.size() != 0) begin
                    n_errors++;
                    $display("FAIL leftover: got %0d pending results required 0", q_res.size());
                end
                $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
                $finish;
            end
        end
    end

endmodule : tb_serial_adder_ctrl

`default_nettype wire
